skew_deskew_stream: RTL
=======================

Name: skew_deskew_stream

Overview:
- Parametrised successor to the fixed per-row delay skewer feeding the systolic array.
- Applies a triangular per-row delay to a vector stream:
  - SKEW mode: row r delayed r beats (activations/weights into the array).
  - DESKEW mode: row r delayed SA_SIZE-1-r beats (realigning array outputs).
- Unlike a free-running shifter, it uses valid/ready handshakes, advances only on beats, zero-fills, self-drains after in_last, and supports a runtime mode and a row mask.

Parameters:
- SA_SIZE, 8, number of rows/lanes; maximum delay is SA_SIZE-1 beats.
- DATA_W, 32, bits per lane element.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- mode  input  1  0=SKEW, 1=DESKEW; sampled on the first accepted beat of a stream
- row_en  input  SA_SIZE  per-row enable, sampled with mode; disabled rows output zero
- in_valid  input  1  input vector valid
- in_ready  output  1  input accepted when in_valid & in_ready
- in_data  input  SA_SIZE x DATA_W  input vector (unpacked array)
- in_last  input  1  marks the final input beat of a stream
- out_valid  output  1  output vector valid
- out_ready  input  1  downstream accepts
- out_data  output  SA_SIZE x DATA_W  skewed/deskewed vector
- out_last  output  1  final output beat of the stream
- busy  output  1  high in STREAM or DRAIN state

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, all delay registers cleared, out_valid=0, out_data all zero, out_last=0, busy=0.
  - Reset mid-stream abandons the stream; no partial output follows.
- Delay d(r):
  - SKEW: d(r)=r.
  - DESKEW: d(r)=SA_SIZE-1-r.
  - Row r holds a shift chain of SA_SIZE-1 registers; the tap is selected by the latched mode.
  - d=0 bypasses the chain.
- Advance:
  - adv = (~out_valid | out_ready) & ((state!=DRAIN & in_valid) | state==DRAIN).
  - in_ready = (state!=DRAIN) & (~out_valid | out_ready). It is combinational, so it never depends on in_valid.
  - On adv, every chain shifts by one:
    - input column = in_data in IDLE/STREAM;
    - input column = all zeros in DRAIN.
  - The output register captures the tapped column and sets out_valid=1.
  - If out_valid & out_ready & ~adv, out_valid clears.
- Output beat j, row r = input beat j-d(r) of the stream, or zero if j-d(r)<0 or the row is masked.
  - A stream of N input beats yields exactly N+SA_SIZE-1 output beats.
- Latency: an output beat is visible the cycle after its advance. Zero stall cycles are added when out_ready is held high.
- FSM:
  - IDLE -> STREAM on the first accepted beat with in_last=0. mode/row_en are latched on this beat.
  - IDLE/STREAM -> DRAIN on an accepted beat with in_last=1, if SA_SIZE>1.
  - DRAIN: 3-bit-minimum counter ($clog2(SA_SIZE)) loads SA_SIZE-1 and decrements per adv. At 0 -> IDLE.
  - SA_SIZE=1: no DRAIN state. out_last accompanies the output of the in_last beat.
- out_last=1 only on the output beat produced by the final drain advance. It is cleared when that beat is consumed.
- A single-beat stream (first beat carries in_last) is legal: latch the mode and go directly to DRAIN.
- mode/row_en changes during STREAM/DRAIN are ignored.
- Invariant: at IDLE all chain registers are zero, because the drain pushes SA_SIZE-1 zero columns. Formal asserts this invariant.
- Backpressure: with out_ready=0 and out_valid=1 there is no advance and out_data holds stable. The AXI-style stability rule is asserted.
- Formal properties:
  - Per row: the output of beat j equals the input of beat j-d(r), counted in advances.
  - No in_ready during DRAIN.

Decomposition:
- GEMM_pkg: typedef skew_mode_e {SKEW=1'b0, DESKEW=1'b1}; typedef skew_state_e {IDLE, STREAM, DRAIN}.
- Sub-module skew_delay_line (DATA_W, DEPTH): enable-shifted chain with a runtime tap select. One instance per row.

Test Plan (SA_SIZE=4, DATA_W=8; in beat k, row r = 0x10*k+r+1; out_ready=1 unless stated):
- SKEW, 2 beats, in_last on beat1 -> 5 output beats:
  - row0: 01,11,00,00,00
  - row3: 00,00,00,04,14
  - out_last on beat4; busy low after.
- DESKEW, same stimulus:
  - row0: 00,00,00,01,11
  - row3: 04,14,00,00,00
  - row1 first nonzero (02) at out beat 2.
- out_ready=0 for 3 cycles mid-stream -> out_data/out_valid stable, in_ready=0; the sequence is identical to the no-stall run.
- row_en=4'b1010, SKEW -> rows 0 and 2 are all zero; rows 1 and 3 match the skew reference.
- Single-beat stream with mode toggled during DRAIN -> 4 output beats in the latched mode; in_ready=0 for 3 drain advances.
- resetn low during STREAM -> next cycle out_valid=0 and busy=0. A new 1-beat stream then yields only its own data, with no stale values.

Source files
------------

// File: rtl/skew_deskew_stream_pkg.sv
// Shared types and helpers for the triangular skew/deskew stream.
package skew_deskew_stream_pkg;

  typedef enum logic {SKEW = 1'b0, DESKEW = 1'b1} skew_mode_e;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} skew_state_e;

  // Select width able to encode 0..n-1, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Beat-enabled shift chain with a runtime tap; tap 0 passes the input through.
module skew_delay_line
  import skew_deskew_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 7
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          en,
  input  logic [DATA_W-1:0]             din,
  input  logic [sel_w(DEPTH+1)-1:0]     tap,
  output logic [DATA_W-1:0]             dout
);

  localparam int unsigned TAP_W = sel_w(DEPTH + 1);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_chain
    logic [DATA_W-1:0] chain [DEPTH];

    // chain[i] holds the column shifted in i+1 beats ago
    always_ff @(posedge clk) begin
      if (!resetn) begin
        chain <= '{default: '0};
      end else if (en) begin
        chain[0] <= din;
        for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
      end
    end

    always_comb begin
      dout = din;
      for (int i = 0; i < DEPTH; i++) begin
        if (tap == TAP_W'(i + 1)) dout = chain[i];
      end
    end
  end

endmodule

// File: rtl/skew_deskew_stream.sv
// Valid/ready triangular row delay: SKEW delays row r by r beats, DESKEW by SA_SIZE-1-r.
module skew_deskew_stream
  import skew_deskew_stream_pkg::*;
#(
  parameter int unsigned SA_SIZE = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mode,
  input  logic [SA_SIZE-1:0]  row_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data [SA_SIZE],
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data [SA_SIZE],
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned DEPTH     = SA_SIZE - 1;
  localparam int unsigned TAP_W     = sel_w(SA_SIZE);
  localparam int unsigned CNT_W     = ($clog2(SA_SIZE) > 3) ? $clog2(SA_SIZE) : 3;
  localparam bit          HAS_DRAIN = (SA_SIZE > 1);

  skew_state_e         state;
  skew_mode_e          mode_q;
  logic [SA_SIZE-1:0]  row_en_q;
  logic [CNT_W-1:0]    cnt;

  logic                adv;
  logic                accept;
  logic                last_adv;
  skew_mode_e          mode_eff;
  logic [SA_SIZE-1:0]  en_eff;
  logic [DATA_W-1:0]   col_in [SA_SIZE];
  logic [DATA_W-1:0]   tapped [SA_SIZE];

  assign in_ready = (state != DRAIN) && (!out_valid || out_ready);
  assign adv      = (!out_valid || out_ready) && ((state == DRAIN) || in_valid);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // The first beat of a stream sees the live mode/mask before they are latched
  assign mode_eff = (state == IDLE) ? skew_mode_e'(mode) : mode_q;
  assign en_eff   = (state == IDLE) ? row_en : row_en_q;
  assign last_adv = HAS_DRAIN ? ((state == DRAIN) && (cnt == CNT_W'(1)))
                              : (accept && in_last);

  for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
    logic [TAP_W-1:0] tap;
    assign tap       = (mode_eff == DESKEW) ? TAP_W'(SA_SIZE - 1 - r) : TAP_W'(r);
    assign col_in[r] = (state == DRAIN) ? '0 : in_data[r];

    skew_delay_line #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_line (
      .clk    (clk),
      .resetn (resetn),
      .en     (adv),
      .din    (col_in[r]),
      .tap    (tap),
      .dout   (tapped[r])
    );

    a_out_stable: assert property (@(posedge clk) disable iff (!resetn)
      (out_valid && !out_ready) |=> $stable(out_data[r]));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mode_q    <= SKEW;
      row_en_q  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '{default: '0};
    end else begin
      if (adv) begin
        out_valid <= 1'b1;
        out_last  <= last_adv;
        for (int r = 0; r < SA_SIZE; r++) out_data[r] <= en_eff[r] ? tapped[r] : '0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            mode_q   <= mode_eff;
            row_en_q <= row_en;
            if (!in_last) begin
              state <= STREAM;
            end else if (HAS_DRAIN) begin
              state <= DRAIN;
              cnt   <= CNT_W'(SA_SIZE - 1);
            end
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            if (HAS_DRAIN) begin
              state <= DRAIN;
              cnt   <= CNT_W'(SA_SIZE - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (adv) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_drain_no_ready: assert property (@(posedge clk) disable iff (!resetn)
    (state == DRAIN) |-> !in_ready);

  a_valid_hold: assert property (@(posedge clk) disable iff (!resetn)
    (out_valid && !out_ready) |=> out_valid);

endmodule
